// File: rtl/balance_pkg.sv
// rtl/balance_pkg.sv - shared state encoding and rider-qualification defaults for the balance sequencer
package balance_pkg;

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        IDLE = 3'd1,
        ARM  = 3'd2,
        RUN  = 3'd3,
        STOP = 3'd4
    } bal_state_t;

    localparam logic [11:0] DEF_MIN_RIDER_WT = 12'h200;
    localparam logic [11:0] DEF_WT_HYST      = 12'h040;
    localparam int          DEF_DBNC_SMPL    = 8;

endpackage

// File: rtl/ss_scale.sv
// rtl/ss_scale.sv - soft-start scaling of the PID output into a registered motor command
module ss_scale (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [11:0] pid_cntrl,
    input  logic        [7:0]  ss_tmr,
    output logic signed [11:0] mtr_cmd
);

    logic signed [20:0] prod;

    // ss_tmr is zero-extended so 0..255 stays positive; 12x9 signed fits 21 bits
    assign prod = 21'(pid_cntrl) * 21'($signed({1'b0, ss_tmr}));

    always_ff @(posedge clk) begin
        if (rst) begin
            mtr_cmd <= '0;
        end else if (en) begin
            mtr_cmd <= 12'(prod >>> 8);
        end else begin
            mtr_cmd <= '0;
        end
    end

endmodule

// File: rtl/balance_seq.sv
// rtl/balance_seq.sv - rider-qualifying sequencer gating the balance PID and soft-starting the motor command
module balance_seq
    import balance_pkg::*;
#(
    parameter logic [11:0] MIN_RIDER_WT = DEF_MIN_RIDER_WT,
    parameter logic [11:0] WT_HYST      = DEF_WT_HYST,
    parameter int          DBNC_SMPL    = DEF_DBNC_SMPL,
    parameter bit          FAST_SIM     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwr_up_req,
    input  logic        sns_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic [11:0] PID_cntrl,
    input  logic [7:0]  ss_tmr,
    output logic        pid_vld,
    output logic        pid_pwr_up,
    output logic        pid_rider_off,
    output logic [11:0] mtr_cmd,
    output logic [2:0]  state_o
);

    localparam int             CW          = $clog2(DBNC_SMPL) + 1;
    localparam logic [CW-1:0]  N_SMPL      = CW'(FAST_SIM ? 2 : DBNC_SMPL);
    localparam logic [12:0]    PRESENT_THR = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0]    ABSENT_THR  = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    bal_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [12:0]   ld_sum;
    logic          present, absent;
    logic          pwr_up_d, rider_off_d, vld_d, run_nxt;

    assign ld_sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign present = (ld_sum >= PRESENT_THR);
    assign absent  = (ld_sum < ABSENT_THR);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Power removal overrides everything, including a debounce completing this cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!pwr_up_req) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
        end else begin
            case (state)
                OFF: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
                IDLE: begin
                    if (sns_vld && present) begin
                        state_nxt = ARM;
                        cnt_nxt   = CW'(1);
                    end
                end
                ARM: begin
                    if (sns_vld) begin
                        if (!present) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else if (cnt_inc == N_SMPL) begin
                            state_nxt = RUN;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                RUN: begin
                    if (sns_vld) begin
                        if (!absent) begin
                            cnt_nxt = '0;
                        end else if (cnt_inc == N_SMPL) begin
                            state_nxt = STOP;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                STOP: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
                default: begin
                    state_nxt = OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pwr_up_d    = (state_nxt == ARM) || (state_nxt == RUN);
        rider_off_d = (state_nxt == OFF) || (state_nxt == IDLE) || (state_nxt == STOP);
        vld_d       = sns_vld && (state == RUN);
        run_nxt     = (state_nxt == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pid_vld       <= 1'b0;
            pid_pwr_up    <= 1'b0;
            pid_rider_off <= 1'b1;
        end else begin
            pid_vld       <= vld_d;
            pid_pwr_up    <= pwr_up_d;
            pid_rider_off <= rider_off_d;
        end
    end

    ss_scale u_ss_scale (
        .clk       (clk),
        .rst       (rst),
        .en        (run_nxt),
        .pid_cntrl (PID_cntrl),
        .ss_tmr    (ss_tmr),
        .mtr_cmd   (mtr_cmd)
    );

    assign state_o = state;

endmodule

// File: tb/tb_balance_seq.sv
// tb/tb_balance_seq.sv - scoreboard bench for balance_seq against a behavioural rider-sequencing model
module tb_balance_seq;

    localparam int N_DBNC  = 8;
    localparam int MIN_WT  = 512;
    localparam int HYST_WT = 64;
    localparam int M_OFF = 0, M_IDLE = 1, M_ARM = 2, M_RUN = 3, M_STOP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwr_up_req = 1'b0;
    logic        sns_vld = 1'b0;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic [11:0] PID_cntrl = '0;
    logic [7:0]  ss_tmr = '0;
    logic        pid_vld, pid_pwr_up, pid_rider_off;
    logic [11:0] mtr_cmd;
    logic [2:0]  state_o;

    typedef struct packed {
        logic [2:0]  st;
        logic        vld;
        logic        pwr;
        logic        roff;
        logic [11:0] mtr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_mode = M_OFF;
    int   m_streak = 0;
    logic [11:0] cur_pid = 12'h123;
    logic [7:0]  cur_tmr = 8'h40;

    always #5 clk = ~clk;

    balance_seq dut (
        .clk           (clk),
        .rst           (rst),
        .pwr_up_req    (pwr_up_req),
        .sns_vld       (sns_vld),
        .lft_ld        (lft_ld),
        .rght_ld       (rght_ld),
        .PID_cntrl     (PID_cntrl),
        .ss_tmr        (ss_tmr),
        .pid_vld       (pid_vld),
        .pid_pwr_up    (pid_pwr_up),
        .pid_rider_off (pid_rider_off),
        .mtr_cmd       (mtr_cmd),
        .state_o       (state_o)
    );

    // Reference: rider mode plus a count of consecutive qualifying samples, evaluated per clock
    task automatic step(input logic r, input logic p, input logic v, input int sum);
        exp_t e;
        int   lo, hi, nxt, prod, pid_i;
        logic rider_on, rider_gone;
        @(negedge clk);
        lo = (sum > 4095) ? sum - 4095 : 0;
        hi = (sum < 4095) ? sum : 4095;
        rst        = r;
        pwr_up_req = p;
        sns_vld    = v;
        lft_ld     = 12'($urandom_range(hi, lo));
        rght_ld    = 12'(sum - int'(lft_ld));
        PID_cntrl  = cur_pid;
        ss_tmr     = cur_tmr;

        rider_on   = (sum >= MIN_WT);
        rider_gone = (sum < MIN_WT - HYST_WT);
        e.vld = !r && v && (m_mode == M_RUN);
        nxt = m_mode;
        if (r || !p) begin
            nxt = M_OFF;
            m_streak = 0;
        end else if (m_mode == M_OFF || m_mode == M_STOP) begin
            nxt = (m_mode == M_OFF) ? M_IDLE : M_IDLE;
            m_streak = 0;
        end else if (v) begin
            if (m_mode == M_IDLE && rider_on) begin
                nxt = M_ARM;
                m_streak = 1;
            end else if (m_mode == M_ARM) begin
                m_streak = rider_on ? m_streak + 1 : 0;
                if (!rider_on) nxt = M_IDLE;
                else if (m_streak == N_DBNC) begin nxt = M_RUN; m_streak = 0; end
            end else if (m_mode == M_RUN) begin
                m_streak = rider_gone ? m_streak + 1 : 0;
                if (m_streak == N_DBNC) begin nxt = M_STOP; m_streak = 0; end
            end
        end
        m_mode = nxt;

        pid_i = $signed(cur_pid);
        prod  = (pid_i * int'(cur_tmr)) >>> 8;
        e.st   = 3'(nxt);
        e.pwr  = (nxt == M_ARM) || (nxt == M_RUN);
        e.roff = (nxt == M_OFF) || (nxt == M_IDLE) || (nxt == M_STOP);
        e.mtr  = (nxt == M_RUN) ? prod[11:0] : 12'h000;
        sb.push_back(e);
    endtask

    task automatic pulse(input int sum);
        step(1'b0, 1'b1, 1'b1, sum);
        step(1'b0, 1'b1, 1'b0, sum);
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {state_o, pid_vld, pid_pwr_up, pid_rider_off, mtr_cmd};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL out_cmp t=%0t got st=%0d vld=%b pwr=%b roff=%b mtr=%h exp st=%0d vld=%b pwr=%b roff=%b mtr=%h",
                             $time, a.st, a.vld, a.pwr, a.roff, a.mtr, e.st, e.vld, e.pwr, e.roff, e.mtr);
                end
            end
        end
    end

    initial begin : driver
        int sums[10] = '{'h300, 'h200, 'h1FF, 'h1C0, 'h1BF, 'h100, 'h1D0, 'h1FFE, 'h300, 'h250};
        int wait_cyc;
        repeat (3) step(1'b1, 1'b0, 1'b0, 0);

        step(1'b0, 1'b1, 1'b0, 'h300);
        repeat (8) pulse('h300);
        repeat (4) pulse('h300);

        repeat (20) pulse('h1D0);
        repeat (8) pulse('h100);
        repeat (2) step(1'b0, 1'b1, 1'b0, 'h100);

        repeat (5) pulse('h300);
        pulse('h100);
        repeat (8) pulse('h300);

        cur_pid = 12'h400; cur_tmr = 8'h80;
        repeat (2) step(1'b0, 1'b1, 1'b0, 'h300);
        cur_pid = 12'hC00; cur_tmr = 8'hFF;
        repeat (2) step(1'b0, 1'b1, 1'b0, 'h300);

        repeat (7) pulse('h100);
        step(1'b0, 1'b0, 1'b1, 'h100);
        step(1'b0, 1'b0, 1'b0, 'h300);
        step(1'b0, 1'b1, 1'b0, 'h300);
        repeat (8) pulse('h300);
        cur_pid = 12'h7FF; cur_tmr = 8'hFF;
        step(1'b0, 1'b1, 1'b0, 'h300);
        step(1'b1, 1'b1, 1'b1, 'h300);
        step(1'b0, 1'b1, 1'b0, 'h300);

        for (int i = 0; i < 800; i++) begin
            cur_pid = 12'($urandom);
            cur_tmr = 8'($urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 2) == 0), sums[$urandom_range(0, 9)]);
        end

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
